// File: rtl/enum_sweep_if.sv
// enum_sweep_if: valid/ready stream carrying canonical permutation codes
// from the sweep engine to the table builder.
interface enum_sweep_if #(
  parameter int PW = 12
);
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_prm;

  modport master (
    output out_valid,
    output out_prm,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_prm,
    output out_ready
  );
endinterface

// File: rtl/enum_sweep.sv
// enum_sweep: walks every permutation code through the enumerate classifier.
// Define ENUM_SWEEP_STREAM_EN to enable the canonical-code output stream.
module enum_sweep #(
  parameter int PW = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] prm_o,
  input  logic          enm_i,
  output logic [PW:0]   cnt,
  enum_sweep_if.master  strm
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    FIN
  } st_t;

  st_t  st;
  logic last;
  logic take;
  logic adv;
  logic drained;

  assign last = (prm_o == '1);

`ifdef ENUM_SWEEP_STREAM_EN
  logic slot_free;

  // slot frees up in the same cycle it is consumed downstream
  assign slot_free = !strm.out_valid || strm.out_ready;
  assign take      = (st == SWEEP) && enm_i && slot_free;
  assign adv       = !enm_i || slot_free;
  assign drained   = slot_free;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      strm.out_valid <= 1'b0;
      strm.out_prm   <= '0;
    end else if (abort) begin
      strm.out_valid <= 1'b0;
    end else if (take) begin
      strm.out_valid <= 1'b1;
      strm.out_prm   <= prm_o;
    end else if (strm.out_ready) begin
      strm.out_valid <= 1'b0;
    end
  end
`else
  logic unused_rdy;

  assign take           = (st == SWEEP) && enm_i;
  assign adv            = 1'b1;
  assign drained        = 1'b1;
  assign strm.out_valid = 1'b0;
  assign strm.out_prm   = '0;
  assign unused_rdy     = &{1'b0, strm.out_ready};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st    <= IDLE;
      prm_o <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      // the code evaluated in an abort cycle still counts
      if (take) cnt <= cnt + 1'b1;
      if (abort) begin
        st    <= IDLE;
        prm_o <= '0;
        busy  <= 1'b0;
      end else begin
        unique case (st)
          IDLE: begin
            prm_o <= '0;
            if (start) begin
              st   <= SWEEP;
              busy <= 1'b1;
              cnt  <= '0;
            end
          end
          SWEEP: begin
            if (adv) begin
              prm_o <= prm_o + 1'b1;
              if (last) st <= DRAIN;
            end
          end
          DRAIN: begin
            if (drained) begin
              st   <= FIN;
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
          FIN: st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule
